// File: rtl/systolic_feeder.sv
// Feed stage for an NxN systolic multiply array: stores operand matrices A and B,
// clears the cell accumulators, streams skewed rows/columns into the array edges,
// waits for the array to drain, then pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, matrix writes accepted
// S_CLEAR | one cycle, accumulator clear driven to every cell
// S_FEED  | 2N-1 cycles, skewed A rows / B columns on the edges
// S_DRAIN | zero edges while the last products ripple through the array
// S_DONE  | one cycle, results final; writes and a new start accepted
//
// Every output is registered from the current state, so each output lags its
// state by one clock: cell_clr shows one edge after start is taken, the first
// FEED word one edge later, and done 3N+2 edges after start.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_row,
  input  logic [AW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            cell_clr,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge
);

  localparam int CW = $clog2(2 * N);
  // Down-counter reload values; the counter reads 0 on the last cycle of a state.
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   t;
  logic            wr_ok;
  logic            busy_d, done_d, clr_d;
  logic [N*DW-1:0] a_d, b_d;

  logic [DW-1:0] mem_a [N][N];
  logic [DW-1:0] mem_b [N][N];

  assign wr_ok = (state == S_IDLE) || (state == S_DONE);
  // Feed step index counts up while the down-counter runs toward zero.
  assign t     = FEED_LAST - cnt;

  // Operand storage, deliberately kept across reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      if (!wr_sel) mem_a[wr_row][wr_col] <= wr_data;
      else         mem_b[wr_row][wr_col] <= wr_data;
    end
  end

  // State and phase counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and counter reload decisions.
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt != '0) ? cnt - 1'b1 : '0;
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: begin
        state_nx = S_FEED;
        cnt_nx   = FEED_LAST;
      end
      S_FEED:  if (cnt == '0) begin
        state_nx = S_DRAIN;
        cnt_nx   = DRAIN_LAST;
      end
      S_DRAIN: if (cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_CLEAR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output values for the next edge; lanes outside the skew window carry zero.
  always_comb begin
    busy_d = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    done_d = (state == S_DONE);
    clr_d  = (state == S_CLEAR);
    a_d    = '0;
    b_d    = '0;
    if (state == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(t) >= i) && (int'(t) - i < N)) begin
          a_d[i*DW +: DW] = mem_a[i][AW'(int'(t) - i)];
          b_d[i*DW +: DW] = mem_b[AW'(int'(t) - i)][i];
        end
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cell_clr <= 1'b0;
      a_edge   <= '0;
      b_edge   <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      cell_clr <= clr_d;
      a_edge   <= a_d;
      b_edge   <= b_d;
    end
  end

endmodule
